// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU issue stage.
//   - alu_op_e : 4-bit ALU Operation codes understood by the downstream alu
//   - OPC_*    : RV32I major opcodes recognised by the decoder
//   - issue_t  : one decoded, issue-ready entry {operation, src_a, src_b, illegal}
//   - f3_alu_op: funct3 -> base ALU op for the register and immediate ALU groups
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 4;
   localparam int INST_W = 32;

   typedef enum logic [OP_W-1:0] {
      ALU_AND   = 4'b0000,
      ALU_OR    = 4'b0001,
      ALU_ADD   = 4'b0010,
      ALU_SLL   = 4'b0011,
      ALU_XOR   = 4'b0100,
      ALU_SLT   = 4'b0101,
      ALU_SUB   = 4'b0110,
      ALU_SLTU  = 4'b0111,
      ALU_SRL   = 4'b1000,
      ALU_SRA   = 4'b1001,
      ALU_BNE   = 4'b1010,
      ALU_BGE   = 4'b1011,
      ALU_BGEU  = 4'b1100,
      ALU_PASSB = 4'b1101,
      ALU_BEQ   = 4'b1110
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // funct7 values: base encoding, and the alternate one that selects SUB/SRA
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      alu_op_e             operation;
      logic [DATA_W-1:0]   src_a;
      logic [DATA_W-1:0]   src_b;
      logic                illegal;
   } issue_t;

   // Base mapping shared by register and immediate forms; SUB/SRA are
   // selected separately by funct7.
   function automatic alu_op_e f3_alu_op(input logic [2:0] f3);
      alu_op_e op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: purely combinational RV32I decode into one ALU issue entry.
//   instr : instruction word
//   rd1   : rs1 value
//   rd2   : rs2 value
//   pc    : instruction address
//   issue : decoded {operation, src_a, src_b, illegal}; undecodable words give
//           {ALU_AND, 0, 0, 1}
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [INST_W-1:0] instr,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2,
   input  logic [DATA_W-1:0] pc,
   output issue_t            issue
);

   logic [6:0]        opcode;
   logic [2:0]        f3;
   logic [6:0]        f7;
   logic [DATA_W-1:0] imm_i;
   logic [DATA_W-1:0] imm_s;
   logic [DATA_W-1:0] imm_u;
   logic [DATA_W-1:0] shamt;
   logic [DATA_W-1:0] link;

   alu_op_e           op;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              bad;

   // rd is not needed to form ALU operands
   logic unused_rd;
   assign unused_rd = ^instr[11:7];

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign imm_i  = {{(DATA_W-12){instr[31]}}, instr[31:20]};
   assign imm_s  = {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_u  = {instr[31:12], 12'b0};
   assign shamt  = {{(DATA_W-5){1'b0}}, instr[24:20]};
   assign link   = pc + DATA_W'(4);

   always_comb begin
      // NOTE: every variable written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      op  = ALU_AND;
      a   = '0;
      b   = '0;
      bad = 1'b0;

      case (opcode)
         OPC_OP: begin
            a  = rd1;
            b  = rd2;
            op = f3_alu_op(f3);
            if (f7 == F7_ALT && f3 == 3'b000)      op  = ALU_SUB;
            else if (f7 == F7_ALT && f3 == 3'b101) op  = ALU_SRA;
            else if (f7 != F7_BASE)                bad = 1'b1;
         end

         OPC_OP_IMM: begin
            a  = rd1;
            b  = imm_i;
            op = f3_alu_op(f3);
            // Shifts take a 5-bit shamt and keep funct7 as an opcode extension
            if (f3 == 3'b001 || f3 == 3'b101) begin
               b = shamt;
               if (f7 == F7_ALT && f3 == 3'b101) op  = ALU_SRA;
               else if (f7 != F7_BASE)           bad = 1'b1;
            end
         end

         OPC_LOAD: begin
            op = ALU_ADD;
            a  = rd1;
            b  = imm_i;
         end

         OPC_STORE: begin
            op = ALU_ADD;
            a  = rd1;
            b  = imm_s;
         end

         OPC_BRANCH: begin
            a = rd1;
            b = rd2;
            case (f3)
               3'b000:  op  = ALU_BEQ;
               3'b001:  op  = ALU_BNE;
               3'b100:  op  = ALU_SLT;
               3'b101:  op  = ALU_BGE;
               3'b110:  op  = ALU_SLTU;
               3'b111:  op  = ALU_BGEU;
               default: bad = 1'b1;
            endcase
         end

         OPC_LUI: begin
            op = ALU_PASSB;
            b  = imm_u;
         end

         OPC_AUIPC: begin
            op = ALU_ADD;
            a  = pc;
            b  = imm_u;
         end

         // Jumps only produce the link value here; the target is formed elsewhere
         OPC_JAL: begin
            op = ALU_PASSB;
            b  = link;
         end

         OPC_JALR: begin
            op = ALU_PASSB;
            b  = link;
            if (f3 != 3'b000) bad = 1'b1;
         end

         default: bad = 1'b1;
      endcase

      // Undecodable words still issue, but with neutral operands
      issue.illegal   = bad;
      issue.operation = bad ? ALU_AND : op;
      issue.src_a     = bad ? '0 : a;
      issue.src_b     = bad ? '0 : b;
   end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: registered decode-and-issue stage in front of the ALU.
// Decoded entries pass through a 2-entry skid buffer (main drives outputs,
// skid catches one extra entry) so that in_ready is a pure register output.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : upstream handshake; in_ready = ~skid_full
//   Instr, RD1, RD2, PC  : instruction and operands
//   out_valid / out_ready: downstream (ALU) handshake
//   SrcA, SrcB, Operation: registered ALU operands and op code
//   illegal              : issued entry could not be decoded
module alu_issue
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int INST_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [INST_WIDTH-1:0]    Instr,
   input  logic [DATA_WIDTH-1:0]    RD1,
   input  logic [DATA_WIDTH-1:0]    RD2,
   input  logic [DATA_WIDTH-1:0]    PC,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    SrcA,
   output logic [DATA_WIDTH-1:0]    SrcB,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     illegal
);

   issue_t dec;
   issue_t main_q;
   issue_t skid_q;
   logic   main_valid;
   logic   skid_full;
   logic   accept;
   logic   consume;

   alu_op_decode u_decode (
      .instr (Instr),
      .rd1   (RD1),
      .rd2   (RD2),
      .pc    (PC),
      .issue (dec)
   );

   assign accept  = in_valid & ~skid_full;
   assign consume = main_valid & out_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the entry registers are reset too, because the outputs they
      // drive must read as zero while in reset.
      if (!rst_n) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_valid <= 1'b0;
         skid_full  <= 1'b0;
      end else begin
         if (consume && skid_full) begin
            // in_ready was low, so nothing can arrive this cycle
            main_q    <= skid_q;
            skid_full <= 1'b0;
         end else if (accept && (!main_valid || consume)) begin
            main_q     <= dec;
            main_valid <= 1'b1;
         end else if (accept) begin
            skid_q    <= dec;
            skid_full <= 1'b1;
         end else if (consume) begin
            main_valid <= 1'b0;
         end
      end
   end

   assign in_ready  = ~skid_full;
   assign out_valid = main_valid;
   assign Operation = main_q.operation;
   assign SrcA      = main_q.src_a;
   assign SrcB      = main_q.src_b;
   assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: self-checking bench for alu_issue. A behavioural model (an
// RV32I decode table plus a depth-2 FIFO) predicts every output each cycle;
// directed cases pin the model with hand-computed values.
module tb_alu_issue;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] Instr;
   logic [31:0] RD1;
   logic [31:0] RD2;
   logic [31:0] PC;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [3:0]  Operation;
   logic        illegal;

   int total = 0;
   int bad   = 0;
   bit checking = 0;

   alu_issue dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Instr     (Instr),
      .RD1       (RD1),
      .RD2       (RD2),
      .PC        (PC),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .Operation (Operation),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        ill;
   } exp_t;

   exp_t mq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t r;
      r.op = op; r.a = a; r.b = b; r.ill = 1'b0;
      return r;
   endfunction

   // Reference decode straight from the RV32I table
   function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] rd1,
                                         input logic [31:0] rd2, input logic [31:0] pc);
      logic [3:0]  by_f3 [8];
      logic [3:0]  br    [8];
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] iimm, simm, uimm, sh;
      exp_t        r;
      by_f3 = '{4'h2, 4'h3, 4'h5, 4'h7, 4'h4, 4'h8, 4'h1, 4'h0};
      br    = '{4'hE, 4'hA, 4'h0, 4'h0, 4'h5, 4'hB, 4'h7, 4'hC};
      opc  = ins[6:0];
      f3   = ins[14:12];
      f7   = ins[31:25];
      iimm = 32'($signed(ins[31:20]));
      simm = 32'($signed({ins[31:25], ins[11:7]}));
      uimm = {ins[31:12], 12'h000};
      sh   = {27'd0, ins[24:20]};
      r.op = 4'h0; r.a = 32'h0; r.b = 32'h0; r.ill = 1'b1;
      case (opc)
         7'h33: begin
            if (f7 == 7'h00)                  r = mk(by_f3[f3], rd1, rd2);
            else if (f7 == 7'h20 && f3 == 0)  r = mk(4'h6, rd1, rd2);
            else if (f7 == 7'h20 && f3 == 5)  r = mk(4'h9, rd1, rd2);
         end
         7'h13: begin
            if (f3 != 1 && f3 != 5)           r = mk(by_f3[f3], rd1, iimm);
            else if (f7 == 7'h00)             r = mk(by_f3[f3], rd1, sh);
            else if (f7 == 7'h20 && f3 == 5)  r = mk(4'h9, rd1, sh);
         end
         7'h03: r = mk(4'h2, rd1, iimm);
         7'h23: r = mk(4'h2, rd1, simm);
         7'h63: if (f3 != 2 && f3 != 3) r = mk(br[f3], rd1, rd2);
         7'h37: r = mk(4'hD, 32'h0, uimm);
         7'h17: r = mk(4'h2, pc, uimm);
         7'h6F: r = mk(4'hD, 32'h0, pc + 32'd4);
         7'h67: if (f3 == 0) r = mk(4'hD, 32'h0, pc + 32'd4);
         default: ;
      endcase
      return r;
   endfunction

   // Stage modelled as a 2-deep FIFO: ready while fewer than two held
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
      end else begin
         bit acc, con;
         acc = in_valid && (mq.size() < 2);
         con = (mq.size() > 0) && out_ready;
         if (con) void'(mq.pop_front());
         if (acc) mq.push_back(model_decode(Instr, RD1, RD2, PC));
      end
   end

   always @(negedge clk) begin
      if (checking && rst_n) begin
         check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
         check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
         if (mq.size() > 0) begin
            check("Operation", 32'(Operation), 32'(mq[0].op));
            check("SrcA", SrcA, mq[0].a);
            check("SrcB", SrcB, mq[0].b);
            check("illegal", 32'(illegal), 32'(mq[0].ill));
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc);
      in_valid = v; Instr = ins; RD1 = a; RD2 = b; PC = pc;
   endtask

   // One instruction into an empty stage, then literal check of the issued entry
   task automatic issue_lit(input string nm, input logic [31:0] ins, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] pc, input logic [3:0] e_op,
                            input logic [31:0] e_a, input logic [31:0] e_b, input logic e_ill);
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive(1'b1, ins, a, b, pc);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check({nm, "_valid"}, 32'(out_valid), 32'd1);
      check({nm, "_op"}, 32'(Operation), 32'(e_op));
      check({nm, "_a"}, SrcA, e_a);
      check({nm, "_b"}, SrcB, e_b);
      check({nm, "_ill"}, 32'(illegal), 32'(e_ill));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  opcs [9];
      logic [31:0] w;
      int          k;
      int          f;
      opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
      w = $urandom();
      k = $urandom_range(0, 11);
      if (k < 9) begin
         w[6:0] = opcs[k];
         f = $urandom_range(0, 3);
         if (f == 0)      w[31:25] = 7'h00;
         else if (f == 1) w[31:25] = 7'h20;
      end
      return w;
   endfunction

   initial begin
      logic [3:0] seen[$];
      bit         rdy;

      rst_n = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      #1 rst_n = 1'b0;
      #3;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_op", 32'(Operation), 32'd0);
      check("rst_srca", SrcA, 32'd0);
      check("rst_srcb", SrcB, 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      #8 rst_n = 1'b1;
      checking = 1;

      // Directed decode cases with hand-computed expectations
      issue_lit("add",   32'h002081B3, 32'd5, 32'd7, 32'h0, 4'h2, 32'd5, 32'd7, 1'b0);
      issue_lit("sub",   32'h402081B3, 32'd9, 32'd4, 32'h0, 4'h6, 32'd9, 32'd4, 1'b0);
      issue_lit("srai",  32'h40315093, 32'h80000000, 32'h0, 32'h0, 4'h9, 32'h80000000, 32'h3, 1'b0);
      issue_lit("srli",  32'h00315093, 32'h80000000, 32'h0, 32'h0, 4'h8, 32'h80000000, 32'h3, 1'b0);
      issue_lit("lui",   32'h123452B7, 32'h1, 32'h2, 32'h0, 4'hD, 32'h0, 32'h12345000, 1'b0);
      issue_lit("jal",   32'h0000006F, 32'h1, 32'h2, 32'hFFFFFFFC, 4'hD, 32'h0, 32'h0, 1'b0);
      issue_lit("allf",  32'hFFFFFFFF, 32'h5, 32'h7, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1);
      issue_lit("br010", 32'h0020A063, 32'h5, 32'h7, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1);

      // Backpressure: A, B, C back to back with the ALU stalled
      @(posedge clk); #1;
      out_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 32'h0);
      @(posedge clk); #1;
      drive(1'b1, 32'h402081B3, 32'd9, 32'd4, 32'h0);
      @(posedge clk); #1;
      drive(1'b1, 32'h0020C1B3, 32'd3, 32'd6, 32'h0);
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_op", 32'(Operation), 32'h2);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("bp_still_full", 32'(in_ready), 32'd0);
      check("bp_hold_a", SrcA, 32'd5);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (out_valid) seen.push_back(Operation);
         rdy = in_ready;
         @(posedge clk); #1;
         if (rdy) in_valid = 1'b0;
      end
      check("bp_count", 32'(seen.size()), 32'd3);
      if (seen.size() == 3) begin
         check("bp_first", 32'(seen[0]), 32'h2);
         check("bp_second", 32'(seen[1]), 32'h6);
         check("bp_third", 32'(seen[2]), 32'h4);
      end

      // Randomized traffic with random backpressure
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         drive($urandom_range(0, 3) != 0, rand_instr(), $urandom(), $urandom(), $urandom());
         out_ready = $urandom_range(0, 3) != 0;
      end

      // Asynchronous reset with both entries full
      @(posedge clk); #1;
      out_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'd1, 32'd2, 32'h0);
      repeat (3) @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("full_out_valid", 32'(out_valid), 32'd1);
      check("full_in_ready", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_op", 32'(Operation), 32'd0);
      check("arst_srca", SrcA, 32'd0);
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_empty", 32'(out_valid), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
